instruction_encoder_loader: RTL and testbench
=============================================

// Module: instruction_encoder_loader
// PURPOSE
//  Inverse of the instruction decode stage. Accepts decoded instruction fields
//  (opcode/rd/rs1/rs2/funct3/funct7/imm) over a valid/ready stream and packs them
//  into 32-bit RV32I words by format (I/U/S/R/SB/UJ). Writes the words sequentially
//  into the instruction-memory write port. Used by the bench and by the boot loader
//  to build programs for the pipeline.
// PARAMETERS
//  ADDR_W     10  byte-address width of the imem write port
//  BASE_ADDR  0   byte address of the first word written after start
//  DEPTH      256 max words per load session (DEPTH*4 <= 2**ADDR_W)
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse; begins a load session (ignored unless IDLE)
//  in_valid     in   1       field tuple valid
//  in_ready     out  1       encoder can accept a tuple this cycle
//  in_last      in   1       tuple is the final instruction of the program
//  opcode       in   7       instruction opcode
//  rd,rs1,rs2   in   5 each  register indices
//  funct3       in   3       funct3 field
//  funct7       in   7       funct7 field (R-type only)
//  imm          in   32      immediate, unshifted byte value (U: full 32-bit value)
//  imem_we      out  1       write strobe to instruction memory
//  imem_addr    out  ADDR_W  byte address of write (word aligned)
//  imem_wdata   out  32      encoded instruction word
//  word_count   out  $clog2(DEPTH+1)  words written this session
//  done         out  1       1-cycle pulse, session finished
//  err_misalign out  1       sticky: SB/UJ imm[0]==1 seen this session
//  err_full     out  1       sticky: DEPTH words written without in_last
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, imem_we, done, err_* = 0; imem_addr=BASE_ADDR;
//   imem_wdata=0; word_count=0. Reset mid-session drops any in-flight word (no write).
//  Format from opcode: 03/13/1B/67->I; 17/37->U; 23->S; 33/3B->R; 63->SB; 6F->UJ;
//   any other -> I (same mapping as decode).
//  Packing: R {funct7,rs2,rs1,funct3,rd,op}; I {imm[11:0],rs1,funct3,rd,op};
//   S {imm[11:5],rs2,rs1,funct3,imm[4:0],op};
//   SB {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op};
//   U {imm[31:12],rd,op}; UJ {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//   Out-of-range imm bits are discarded silently. For SB/UJ, imm[0] is dropped and
//   err_misalign is set.
//  FSM: IDLE --start--> LOAD (word_count<=0, next addr<=BASE_ADDR, err_*<=0).
//   LOAD: in_ready=1 iff word_count+pending < DEPTH. Accept = in_valid&in_ready.
//   On accept in cycle N: encode comb, register; imem_we=1 in cycle N+1 with
//   imem_addr=current addr, then addr+=4 and word_count+=1 (latency 1, throughput 1/clk).
//   Accept with in_last -> FLUSH (in_ready=0). FLUSH: final write done -> DONE.
//   Count reaches DEPTH without in_last -> err_full<=1, go to DONE.
//   DONE: done=1 for exactly one cycle -> IDLE. imem_we=0 outside write cycles.
//  in_valid while not ready is held off (no accept). Tuple fields must stay stable until
//   accepted. start outside IDLE has no effect. imem_addr holds its last value when idle.
//  Address wrap not possible: DEPTH bound enforced before wrap.
// TESTING
//  R: op=33 rd=3 rs1=1 rs2=2 f3=0 f7=0 -> cycle+1 we=1 addr=0 wdata=0x002081B3
//  I/S stream: addi x1,x0,5 then sw x2,8(x1) back-to-back -> 0x00500093@0, 0x0020A423@4
//  SB/UJ: beq x1,x2,imm=-4 -> 0xFE208EE3; jal x1,imm=16 -> 0x010000EF; imm=3 -> err_misalign
//  U + last: lui x5,imm=0x12345000 with in_last -> 0x123452B7, done 1 cycle after write
//  DEPTH=4, 5 tuples no last -> 4 writes, err_full=1, done pulse, 5th never readied
//  rst asserted the cycle after an accept -> no imem_we; all outputs at reset values

Source files
------------

// File: rtl/instruction_encoder_loader.sv
// Packs decoded RV32I fields into instruction words and streams them
// sequentially into the instruction-memory write port.
module instruction_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH = 256,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [CW-1:0]     word_count,
  output logic              done,
  output logic              err_misalign,
  output logic              err_full
);

  localparam int CW1 = CW + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  typedef enum logic [2:0] {
    FMT_I, FMT_U, FMT_S, FMT_R, FMT_SB, FMT_UJ
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE, LOAD, FLUSH, DONE
  } state_e;

  state_e            state;
  fmt_e              fmt;
  logic [31:0]       enc;
  logic              we_q;
  logic [ADDR_W-1:0] waddr;
  logic [CW:0]       occ;
  logic              accept;
  logic              misalign;
  logic              full_hit;

  always_comb begin
    fmt = FMT_I;
    case (opcode)
      7'h17, 7'h37: fmt = FMT_U;
      7'h23:        fmt = FMT_S;
      7'h33, 7'h3B: fmt = FMT_R;
      7'h63:        fmt = FMT_SB;
      7'h6F:        fmt = FMT_UJ;
      default:      fmt = FMT_I;
    endcase
  end

  always_comb begin
    enc = '0;
    unique case (1'b1)
      (fmt == FMT_R):
        enc = {funct7, rs2, rs1, funct3, rd, opcode};
      (fmt == FMT_S):
        enc = {imm[11:5], rs2, rs1, funct3,
               imm[4:0], opcode};
      (fmt == FMT_SB):
        enc = {imm[12], imm[10:5], rs2, rs1, funct3,
               imm[4:1], imm[11], opcode};
      (fmt == FMT_U):
        enc = {imm[31:12], rd, opcode};
      (fmt == FMT_UJ):
        enc = {imm[20], imm[10:1], imm[11],
               imm[19:12], rd, opcode};
      default:
        enc = {imm[11:0], rs1, funct3, rd, opcode};
    endcase
  end

  // Occupancy counts the word still waiting in the write register.
  assign occ = {1'b0, word_count} + {{CW{1'b0}}, we_q};
  assign in_ready = !rst && (state == LOAD) && (occ < DEPTH_W);
  assign accept = in_valid && in_ready;
  assign misalign = imm[0] && ((fmt == FMT_SB) || (fmt == FMT_UJ));
  assign full_hit = we_q && (word_count == LAST_C);

  // A reset arriving during the write cycle suppresses that write.
  assign imem_we = we_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      waddr        <= BASE;
      imem_addr    <= BASE;
      imem_wdata   <= '0;
      word_count   <= '0;
      done         <= 1'b0;
      err_misalign <= 1'b0;
      err_full     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      done <= 1'b0;
      if (we_q) begin
        word_count <= word_count + CW'(1);
      end
      if (accept) begin
        we_q       <= 1'b1;
        imem_wdata <= enc;
        imem_addr  <= waddr;
        waddr      <= waddr + STEP;
        if (misalign) begin
          err_misalign <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            word_count   <= '0;
            waddr        <= BASE;
            err_misalign <= 1'b0;
            err_full     <= 1'b0;
          end
        end
        LOAD: begin
          if (full_hit) begin
            err_full <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else if (accept && in_last) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (we_q) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench for instruction_encoder_loader with a write scoreboard.
module tb_instruction_encoder_loader;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          imem_we;
  logic [9:0]    imem_addr;
  logic [31:0]   imem_wdata;
  logic [CW-1:0] word_count;
  logic          done;
  logic          err_misalign;
  logic          err_full;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t     q[$];
  int       total = 0;
  int       bad = 0;
  int       nwrites = 0;
  logic [9:0] exp_addr = '0;

  instruction_encoder_loader #(
    .ADDR_W(10),
    .BASE_ADDR(0),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .opcode(opcode),
    .rd(rd),
    .rs1(rs1),
    .rs2(rs2),
    .funct3(funct3),
    .funct7(funct7),
    .imm(imm),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .word_count(word_count),
    .done(done),
    .err_misalign(err_misalign),
    .err_full(err_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      exp_t e;
      nwrites++;
      chk("write_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("imem_addr", 32'(imem_addr), 32'(e.a));
        chk("imem_wdata", imem_wdata, e.d);
      end
    end
  end

  task automatic begin_session();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = '0;
    chk("session_wc0", 32'(word_count), 32'd0);
  endtask

  task automatic send(input logic [6:0] op,
                      input logic [4:0] d,
                      input logic [4:0] s1,
                      input logic [4:0] s2,
                      input logic [2:0] f3,
                      input logic [6:0] f7,
                      input logic [31:0] im,
                      input logic last,
                      input logic [31:0] word);
    int n;
    @(negedge clk);
    opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(n < 20), 32'd1);
    q.push_back('{a: exp_addr, d: word});
    exp_addr += 10'd4;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int w0;
    int dcnt;
    int rcnt;
    rst = 1'b1; start = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_errs", {30'd0, err_misalign, err_full}, 32'd0);
    rst = 1'b0;

    begin_session();
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,
         1'b1, 32'h002081B3);
    idle();
    wait_done();
    chk("r_wc", 32'(word_count), 32'd1);

    begin_session();
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,
         1'b0, 32'h00500093);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,
         1'b1, 32'h0020A423);
    idle();
    wait_done();
    chk("is_wc", 32'(word_count), 32'd2);

    begin_session();
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4,
         1'b0, 32'hFE208EE3);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16,
         1'b0, 32'h010000EF);
    idle();
    chk("aligned_no_err", 32'(err_misalign), 32'd0);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,
         1'b1, 32'h002000EF);
    idle();
    wait_done();
    chk("misalign_set", 32'(err_misalign), 32'd1);
    chk("sbuj_wc", 32'(word_count), 32'd3);

    begin_session();
    chk("misalign_cleared", 32'(err_misalign), 32'd0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,
         1'b1, 32'h123452B7);
    idle();
    chk("u_write_cycle", 32'(imem_we), 32'd1);
    chk("u_done_early", 32'(done), 32'd0);
    chk("flush_not_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("u_done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    chk("u_done_off", 32'(done), 32'd0);
    chk("u_wc", 32'(word_count), 32'd1);
    chk("u_no_full", 32'(err_full), 32'd0);

    begin_session();
    w0 = nwrites;
    for (int i = 0; i < 4; i++) begin
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1),
           1'b0, 32'h00000093 | (32'(i + 1) << 20));
    end
    @(negedge clk);
    imm = 32'd9;
    dcnt = 0;
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) rcnt++;
      if (done) dcnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_fifth_ready", 32'(rcnt), 32'd0);
    chk("full_done_pulses", 32'(dcnt), 32'd1);
    chk("full_writes", 32'(nwrites - w0), 32'd4);
    chk("full_err", 32'(err_full), 32'd1);
    chk("full_wc", 32'(word_count), 32'd4);

    begin_session();
    @(negedge clk);
    opcode = 7'h13; rd = 5'd7; imm = 32'd1;
    in_last = 1'b0;
    in_valid = 1'b1;
    chk("rst_case_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_drop_we", 32'(imem_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_wc", 32'(word_count), 32'd0);
    chk("mid_rst_errs", {30'd0, err_misalign, err_full}, 32'd0);
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
